// File: rtl/spi_dac_rx_if.sv
// spi_dac_rx_if: bundle between the DAC-link SPI master/consumer and spi_dac_rx.
// master drives spi_clk/spi_mosi/spi_cs/rx_ready; slave returns rx_data/rx_valid/busy/overrun/frame_err.
interface spi_dac_rx_if #(
  parameter int DATA_W = 16
);
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_cs;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              overrun;
  logic              frame_err;

  modport master (
    output spi_clk,
    output spi_mosi,
    output spi_cs,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  busy,
    input  overrun,
    input  frame_err
  );

  modport slave (
    input  spi_clk,
    input  spi_mosi,
    input  spi_cs,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output busy,
    output overrun,
    output frame_err
  );
endinterface

// File: rtl/spi_dac_rx.sv
// spi_dac_rx: oversampling SPI slave receiver, MSB-first DATA_W-bit frames to valid/ready.
// Ports: clk, rst (async, active high), bus (spi_dac_rx_if.slave).
// Optional macro SPI_DAC_RX_FRAME_CHECK_EN: drop frames with bit count != DATA_W, pulse frame_err.
module spi_dac_rx #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_dac_rx_if.slave  bus
);

  localparam int CW = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  localparam logic [CW-1:0] SAT  = CW'(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    COMMIT
  } state_t;

  state_t state;
  state_t state_n;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   cs_d;
  logic                   clk_d;
  logic                   armed;

  logic                   cs_s;
  logic                   clk_s;
  logic                   mosi_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_rise;

  logic [DATA_W-1:0]      shift;
  logic [CW-1:0]          cnt;

  logic [DATA_W-1:0]      data_q;
  logic                   valid_q;
  logic                   ovr_q;

  logic                   commit;
  logic                   eligible;
  logic                   load;
  logic                   drop;
  logic                   bad_len;

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge detect compares the synchronizer output with one more
  // registered sample; nothing is seen until the block is armed.
  assign cs_fall   = armed & cs_d & ~cs_s;
  assign cs_rise   = armed & ~cs_d & cs_s;
  assign sclk_rise = armed & ~clk_d & clk_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      clk_sync  <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b1;
      clk_d     <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_d      <= cs_s;
      clk_d     <= clk_s;
    end
  end

  // fill marks when the cs chain holds real samples rather than its
  // reset value, so a cs held low through reset never arms the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      if (fill[SYNC_STAGES-1] && cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    commit   = 1'b0;
    eligible = 1'b0;
    bad_len  = 1'b0;
    load     = 1'b0;
    drop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = RECV;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_n = COMMIT;
        end
      end
      COMMIT: begin
        state_n = IDLE;
        commit  = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    bad_len = commit & (cnt != FULL);
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
    eligible = commit & (cnt == FULL);
`else
    eligible = commit & (cnt != '0);
`endif
    load = eligible & (~valid_q | bus.rx_ready);
    drop = eligible & valid_q & ~bus.rx_ready;
  end

  // Count saturates one past DATA_W so long frames stay
  // distinguishable while keeping only their first DATA_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
      cnt   <= '0;
    end else if (state == IDLE && cs_fall) begin
      shift <= '0;
      cnt   <= '0;
    end else if (state == RECV && !cs_rise && sclk_rise) begin
      if (cnt < SAT) begin
        cnt <= cnt + CW'(1);
      end
      if (cnt < FULL) begin
        shift <= {shift[DATA_W-2:0], mosi_s};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= drop;
      if (load) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else if (bus.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_DAC_RX_FRAME_CHECK_EN
  logic ferr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr_q <= 1'b0;
    end else begin
      ferr_q <= bad_len;
    end
  end

  assign bus.frame_err = ferr_q;
`else
  logic unused_len;

  assign unused_len    = bad_len;
  assign bus.frame_err = 1'b0;
`endif

  assign bus.rx_data  = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.overrun  = ovr_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_dac_rx.sv
// tb_spi_dac_rx: directed and random frames against a frame-level
// reference model of spi_dac_rx.
module tb_spi_dac_rx;

  localparam int W = 16;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_dac_rx_if #(.DATA_W(W)) bus ();

  spi_dac_rx #(
    .DATA_W(W),
    .SYNC_STAGES(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    int          n;
  } fr_t;

  fr_t cq[$];
  fr_t f;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run_chk = 0;
  bit done    = 0;

  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovr;
  logic         m_ferr;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(logic [31:0] v, int n);
    logic [31:0] t;
    if (n > W) t = v >> (n - W);
    else       t = v & ((32'd1 << n) - 32'd1);
    return t[W-1:0];
  endfunction

  function automatic bit elig(int n);
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
    return n == W;
`else
    return n != 0;
`endif
  endfunction

  // Frame-level model: a queued frame commits in a known cycle
  // (cs raise + S + 1); everything else is consume-on-ready.
  always @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_ovr   <= 1'b0;
      m_ferr  <= 1'b0;
    end else begin
      m_ovr  <= 1'b0;
      m_ferr <= 1'b0;
      if (cq.size() > 0 && cq[0].cyc == cyc) begin
        f = cq.pop_front();
`ifdef SPI_DAC_RX_FRAME_CHECK_EN
        m_ferr <= (f.n != W);
`endif
        if (elig(f.n) && (!m_valid || bus.rx_ready)) begin
          m_data  <= word_of(f.val, f.n);
          m_valid <= 1'b1;
        end else begin
          if (elig(f.n)) m_ovr <= 1'b1;
          if (bus.rx_ready) m_valid <= 1'b0;
        end
      end else if (bus.rx_ready) begin
        m_valid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("valid", bus.rx_valid, m_valid);
      chk("data", bus.rx_data, m_data);
      chk("overrun", bus.overrun, m_ovr);
      chk("frame_err", bus.frame_err, m_ferr);
    end
  end

  task automatic bit_out(logic b, int ph);
    bus.spi_mosi = b;
    repeat (ph) @(negedge clk);
    bus.spi_clk = 1'b1;
    repeat (ph) @(negedge clk);
    bus.spi_clk = 1'b0;
  endtask

  task automatic send(logic [31:0] v, int n, int ph);
    bus.spi_cs = 1'b0;
    repeat (ph) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      bit_out(v[i], ph);
      if (i == n / 2) chk("busy_mid", bus.busy, 1);
    end
    repeat (ph) @(negedge clk);
    bus.spi_cs = 1'b1;
    cq.push_back(fr_t'{cyc: cyc + S + 1, val: v, n: n});
  endtask

  task automatic idle(int k);
    repeat (k) @(negedge clk);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic consume();
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  initial begin
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.rx_ready = 1'b0;
    #20;
    rst = 1'b0;
    run_chk = 1;
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_busy", bus.busy, 0);
    repeat (4) @(negedge clk);

    send(32'h3F3F, 16, 2);
    repeat (S + 1) @(negedge clk);
    chk("valid_early", bus.rx_valid, 0);
    @(negedge clk);
    chk("valid_on_time", bus.rx_valid, 1);
    idle(6);
    chk("d_3f3f", bus.rx_data, 16'h3F3F);
    consume();

    send(32'hA5A5, 16, 2);
    idle(6);
    send(32'h1234, 16, 2);
    idle(6);
    chk("d_keep_a5a5", bus.rx_data, 16'hA5A5);
    consume();

    send(32'hA5A5, 16, 2);
    idle(6);
    send(32'h1234, 16, 2);
    repeat (S + 1) @(negedge clk);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    idle(6);
    chk("d_1234", bus.rx_data, 16'h1234);
    chk("v_1234", bus.rx_valid, 1);
    consume();

    send(32'hABC, 12, 2);
    idle(6);
`ifndef SPI_DAC_RX_FRAME_CHECK_EN
    chk("d_0abc", bus.rx_data, 16'h0ABC);
`endif
    consume();

    bus.spi_cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) bit_out(1'($urandom), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bit_out(1'($urandom), 2);
      chk("busy_after_rst", bus.busy, 0);
    end
    repeat (2) @(negedge clk);
    bus.spi_cs = 1'b1;
    idle(6);
    chk("v_cut_frame", bus.rx_valid, 0);
    send(32'h8001, 16, 2);
    idle(6);
    chk("d_8001", bus.rx_data, 16'h8001);
    consume();

    send(32'h1FFFE, 17, 2);
    idle(6);
`ifndef SPI_DAC_RX_FRAME_CHECK_EN
    chk("d_ffff", bus.rx_data, 16'hFFFF);
`endif
    consume();

    send(32'h0, 0, 2);
    idle(6);

    fork
      begin
        for (int k = 0; k < 100; k++) begin
          send($urandom & 32'hFFFF, 16, 2);
          repeat ($urandom_range(2, 4)) @(negedge clk);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          bus.rx_ready = 1'($urandom);
        end
      end
    join
    bus.rx_ready = 1'b0;
    idle(8);
    chk("queue_drained", cq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
